// File: rtl/i2c_slave_bus_ctrl.sv
// I2C slave protocol controller: synchronizes SCL/SDA, detects START/STOP, matches the address and sequences ACK/data phases.
// Optional feature macro: I2C_SLAVE_GENERAL_CALL_EN (also ACK the general-call address 7'h00 as a write).
module i2c_slave_bus_ctrl #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h68,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       pclk,
    input  logic       areset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       rw,
    output logic       busy,
    output logic       nack_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_RX_BYTE,
        S_RX_ACK,
        S_TX_BYTE,
        S_TX_ACK,
        S_WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    state_t      r_state;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_drive;
    logic        r_ack_on;
    logic [7:0]  r_rx_byte;
    logic        r_rx_pulse;
    logic        r_nack_pulse;
    logic        r_tx_req;
    logic        r_rw;
    logic        r_busy;

    logic        r_sda_oe;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_nack_err;

    logic        w_scl;
    logic        w_sda;
    logic        w_scl_rise;
    logic        w_scl_fall;
    logic        w_start;
    logic        w_stop;
    logic [7:0]  w_byte;
    logic        w_last_bit;
    logic        w_addr_match;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte     = {r_shift[6:0], w_sda};
    assign w_last_bit = (r_bit_cnt == 3'd7);

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    assign w_addr_match = (w_byte[7:1] == SLAVE_ADDR) || (w_byte == 8'h00);
`else
    assign w_addr_match = (w_byte[7:1] == SLAVE_ADDR);
`endif

    // Synchronizers reset to the idle-bus level so reset itself never looks like a bus event.
    always_ff @(posedge pclk) begin
        if (areset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    always_ff @(posedge pclk) begin
        if (areset) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_drive      <= 1'b0;
            r_ack_on     <= 1'b0;
            r_rx_byte    <= 8'h00;
            r_rx_pulse   <= 1'b0;
            r_nack_pulse <= 1'b0;
            r_tx_req     <= 1'b0;
            r_rw         <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rx_pulse   <= 1'b0;
            r_nack_pulse <= 1'b0;
            r_tx_req     <= 1'b0;
            if (w_start) begin
                r_state   <= S_ADDR;
                r_bit_cnt <= 3'd0;
                r_drive   <= 1'b0;
                r_ack_on  <= 1'b0;
                r_busy    <= 1'b1;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= 3'd0;
                r_drive   <= 1'b0;
                r_ack_on  <= 1'b0;
                r_busy    <= 1'b0;
            end else if (r_tx_req) begin
                // tx_data is valid in the tx_req cycle; the MSB is already on the pin via the output stage.
                r_shift <= tx_data;
                r_drive <= ~tx_data[7];
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                if (w_addr_match) begin
                                    r_state <= S_ADDR_ACK;
                                    r_rw    <= w_byte[0];
                                end else begin
                                    r_state <= S_WAIT_STOP;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK, S_RX_ACK: begin
                        // First falling edge starts the ACK pull-down, the second one ends it.
                        if (w_scl_fall) begin
                            if (!r_ack_on) begin
                                r_drive  <= 1'b1;
                                r_ack_on <= 1'b1;
                            end else begin
                                r_drive   <= 1'b0;
                                r_ack_on  <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                if ((r_state == S_ADDR_ACK) && r_rw) begin
                                    r_state  <= S_TX_BYTE;
                                    r_tx_req <= 1'b1;
                                end else begin
                                    r_state <= S_RX_BYTE;
                                end
                            end
                        end
                    end
                    S_RX_BYTE: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                if (rx_ready) begin
                                    r_rx_byte  <= w_byte;
                                    r_rx_pulse <= 1'b1;
                                    r_state    <= S_RX_ACK;
                                end else begin
                                    r_nack_pulse <= 1'b1;
                                    r_state      <= S_WAIT_STOP;
                                end
                            end
                        end
                    end
                    S_TX_BYTE: begin
                        if (w_scl_fall) begin
                            if (w_last_bit) begin
                                r_drive   <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                r_state   <= S_TX_ACK;
                            end else begin
                                r_drive   <= ~r_shift[6];
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    S_TX_ACK: begin
                        if (w_scl_rise) begin
                            if (!w_sda) begin
                                r_ack_on <= 1'b1;
                            end else begin
                                r_state <= S_WAIT_STOP;
                            end
                        end else if (w_scl_fall && r_ack_on) begin
                            r_ack_on  <= 1'b0;
                            r_tx_req  <= 1'b1;
                            r_bit_cnt <= 3'd0;
                            r_state   <= S_TX_BYTE;
                        end
                    end
                    default: begin
                        r_drive <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Output stage: one register after the FSM reaction.
    always_ff @(posedge pclk) begin
        if (areset) begin
            r_sda_oe   <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_nack_err <= 1'b0;
        end else begin
            r_sda_oe   <= r_tx_req ? ~tx_data[7] : r_drive;
            r_rx_valid <= r_rx_pulse;
            r_nack_err <= r_nack_pulse;
            if (r_rx_pulse) begin
                r_rx_data <= r_rx_byte;
            end
        end
    end

    assign sda_oe   = r_sda_oe;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign nack_err = r_nack_err;
    assign tx_req   = r_tx_req;
    assign rw       = r_rw;
    assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave_bus_ctrl.sv
// Bench for i2c_slave_bus_ctrl: bit-banged I2C master, open-drain SDA model and an rx scoreboard.
`timescale 1ns/1ps
module tb_i2c_slave_bus_ctrl;

    localparam int Q = 8;

    logic       pclk = 1'b0;
    logic       areset;
    logic       scl_m;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       rw;
    logic       busy;
    logic       nack_err;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_bus_ctrl #(.SLAVE_ADDR(7'h68), .SYNC_STAGES(2)) dut (
        .pclk     (pclk),
        .areset   (areset),
        .scl_i    (scl_m),
        .sda_i    (sda_line),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_req   (tx_req),
        .tx_data  (tx_data),
        .rw       (rw),
        .busy     (busy),
        .nack_err (nack_err)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] q_rx[$];
    int rx_hi = 0, tx_hi = 0, nack_hi = 0, drive_viol = 0;
    int exp_rx = 0, exp_tx = 0, exp_nack = 0;
    logic watch_release = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every rx_valid cycle pops one expected byte.
    always @(negedge pclk) begin
        if (!areset) begin
            if (rx_valid) begin
                rx_hi++;
                if (q_rx.size() == 0) begin
                    check_eq("rx_unexpected", 32'(q_rx.size()), 32'd1);
                end else begin
                    logic [7:0] e;
                    e = q_rx.pop_front();
                    $display("txn rx_valid data=%02h exp=%02h", rx_data, e);
                    check_eq("rx_data", 32'(rx_data), 32'(e));
                end
            end
            if (tx_req) tx_hi++;
            if (nack_err) nack_hi++;
            if (watch_release && sda_oe) drive_viol++;
        end
    end

    task automatic wq();
        repeat (Q) @(posedge pclk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
        wq();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; wq();
        scl_m = 1'b1; wq(); wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        @(negedge pclk);
        b = sda_line;
        wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
        $display("txn write byte=%02h ack_bit=%0b", d, ack);
    endtask

    task automatic read_byte(output logic [7:0] d);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        $display("txn read byte=%02h", d);
    endtask

    task automatic check_counts(input string tag);
        @(negedge pclk);
        check_eq({tag, "_rx_cnt"}, 32'(rx_hi), 32'(exp_rx));
        check_eq({tag, "_tx_cnt"}, 32'(tx_hi), 32'(exp_tx));
        check_eq({tag, "_nack_cnt"}, 32'(nack_hi), 32'(exp_nack));
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        logic       gc_exp;

        areset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rx_ready = 1'b1; tx_data = 8'hA5;
        repeat (5) @(posedge pclk);
        @(negedge pclk);
        check_eq("rst_sda_oe", 32'(sda_oe), 32'd0);
        check_eq("rst_rx_data", 32'(rx_data), 32'd0);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_tx_req", 32'(tx_req), 32'd0);
        check_eq("rst_rw", 32'(rw), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_nack_err", 32'(nack_err), 32'd0);
        areset = 1'b0;
        wq();

        // Write 0x5A to address 0x68
        bus_start();
        @(negedge pclk);
        check_eq("wr_busy_hi", 32'(busy), 32'd1);
        write_byte(8'hD0, ack);
        check_eq("wr_addr_ack", 32'(ack), 32'd0);
        check_eq("wr_rw", 32'(rw), 32'd0);
        q_rx.push_back(8'h5A); exp_rx++;
        write_byte(8'h5A, ack);
        check_eq("wr_data_ack", 32'(ack), 32'd0);
        bus_stop();
        @(negedge pclk);
        check_eq("wr_busy_lo", 32'(busy), 32'd0);
        check_counts("wr");

        // Read one byte 0xA5, master NACKs
        tx_data = 8'hA5;
        bus_start();
        write_byte(8'hD1, ack);
        check_eq("rd_addr_ack", 32'(ack), 32'd0);
        check_eq("rd_rw", 32'(rw), 32'd1);
        exp_tx++;
        read_byte(d);
        check_eq("rd_data", 32'(d), 32'hA5);
        write_bit(1'b1);
        wq();
        @(negedge pclk);
        check_eq("rd_wait_stop_busy", 32'(busy), 32'd1);
        check_eq("rd_wait_stop_sda", 32'(sda_oe), 32'd0);
        bus_stop();
        @(negedge pclk);
        check_eq("rd_busy_lo", 32'(busy), 32'd0);
        check_counts("rd");

        // Foreign address 0x50: never pulls SDA
        bus_start();
        watch_release = 1'b1;
        write_byte(8'hA0, ack);
        check_eq("foreign_nack", 32'(ack), 32'd1);
        write_byte(8'h33, ack);
        check_eq("foreign_data_nack", 32'(ack), 32'd1);
        bus_stop();
        watch_release = 1'b0;
        check_eq("foreign_no_drive", 32'(drive_viol), 32'd0);
        check_counts("foreign");

        // Sink not ready: byte is NACKed and dropped
        rx_ready = 1'b0;
        bus_start();
        write_byte(8'hD0, ack);
        check_eq("nr_addr_ack", 32'(ack), 32'd0);
        exp_nack++;
        write_byte(8'h11, ack);
        check_eq("nr_data_nack", 32'(ack), 32'd1);
        bus_stop();
        rx_ready = 1'b1;
        check_eq("nr_rx_hold", 32'(rx_data), 32'h5A);
        check_counts("nr");

        // Repeated START after address ACK, then read two bytes
        tx_data = 8'h3C;
        bus_start();
        write_byte(8'hD0, ack);
        check_eq("rs_wr_ack", 32'(ack), 32'd0);
        bus_start();
        write_byte(8'hD1, ack);
        check_eq("rs_rd_ack", 32'(ack), 32'd0);
        check_eq("rs_rw", 32'(rw), 32'd1);
        exp_tx++;
        read_byte(d);
        check_eq("rs_data0", 32'(d), 32'h3C);
        tx_data = 8'hC3;
        exp_tx++;
        write_bit(1'b0);
        read_byte(d);
        check_eq("rs_data1", 32'(d), 32'hC3);
        write_bit(1'b1);
        bus_stop();
        check_counts("rs");

        // Two-byte write with distinct patterns
        bus_start();
        write_byte(8'hD0, ack);
        check_eq("w2_addr_ack", 32'(ack), 32'd0);
        check_eq("w2_rw", 32'(rw), 32'd0);
        q_rx.push_back(8'hFF); exp_rx++;
        write_byte(8'hFF, ack);
        check_eq("w2_ack0", 32'(ack), 32'd0);
        q_rx.push_back(8'h00); exp_rx++;
        write_byte(8'h00, ack);
        check_eq("w2_ack1", 32'(ack), 32'd0);
        bus_stop();
        check_counts("w2");

        // General call address
`ifdef I2C_SLAVE_GENERAL_CALL_EN
        gc_exp = 1'b0;
`else
        gc_exp = 1'b1;
`endif
        bus_start();
        write_byte(8'h00, ack);
        check_eq("gcall_ack", 32'(ack), 32'(gc_exp));
        bus_stop();
        bus_start();
        write_byte(8'h01, ack);
        check_eq("gcall_read_nack", 32'(ack), 32'd1);
        bus_stop();
        check_counts("gcall");

        // Reset in the middle of an ACK pull-down
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(ack_bit_of(8'hD0, i));
        scl_m = 1'b1; wq();
        @(negedge pclk);
        check_eq("mid_ack_drive", 32'(sda_oe), 32'd1);
        areset = 1'b1;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check_eq("mid_rst_sda", 32'(sda_oe), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_rx_data", 32'(rx_data), 32'd0);
        areset = 1'b0;
        scl_m = 1'b0; wq();
        bus_stop();
        @(negedge pclk);
        check_eq("mid_rst_idle_sda", 32'(sda_oe), 32'd0);

        check_eq("sb_empty", 32'(q_rx.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    function automatic logic ack_bit_of(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule

// File: doc/i2c_slave_bus_ctrl.md
# i2c_slave_bus_ctrl

Synthesizable I2C slave-side protocol controller for the slave agent. It oversamples SCL/SDA on the system clock, detects START/STOP, matches the 7-bit address, and sequences the address, data and ACK phases. Received bytes are delivered on a valid/ready-style port, and transmit bytes are requested per byte. The open-drain SDA pull-down is driven toward the shared `i2c_if` bus, the same pins the slave monitor BFM observes.

## Interface
- `SLAVE_ADDR`, default 7'h68: 7-bit device address to match.
- `SYNC_STAGES`, default 2: synchronizer depth for `scl_i`/`sda_i`; minimum 2.
- `pclk` input 1: system clock, at least 8x SCL frequency.
- `areset` input 1: reset; synchronous, active-high.
- `scl_i` input 1: bus SCL, asynchronous.
- `sda_i` input 1: bus SDA, asynchronous.
- `sda_oe` output 1: 1 pulls SDA low; 0 releases it.
- `rx_data` output 8: last received data byte.
- `rx_valid` output 1: one-cycle pulse when `rx_data` is updated.
- `rx_ready` input 1: sink can accept; sampled at the 8th data bit.
- `tx_req` output 1: one-cycle pulse requesting the next read byte.
- `tx_data` input 8: read byte; sampled in the cycle `tx_req`=1.
- `rw` output 1: R/W bit of the current addressed transfer (1 = read).
- `busy` output 1: high from START to STOP.
- `nack_err` output 1: one-cycle pulse when the controller NACKs a written byte.

## Operation
- Sync: `scl_i`/`sda_i` pass through `SYNC_STAGES` flops. One further register provides edge detection.
- Bus conditions (SCL high while SDA changes):
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
  - Both take priority over bit events in the same cycle.
- Bits are sampled on SCL rising edges. SDA is changed only on SCL falling edges. A 3-bit counter counts the MSB-first bits.
- FSM states: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
  - IDLE: START -> ADDR.
  - ADDR: after 8 bits, if the address matches `SLAVE_ADDR` -> ADDR_ACK and `rw` is latched; otherwise -> WAIT_STOP with SDA released.
  - ADDR_ACK: `sda_oe`=1 from the falling SCL after bit 8 to the falling SCL after bit 9. Then -> RX_BYTE if write. If read, -> TX_BYTE and pulse `tx_req` at that falling edge.
  - RX_BYTE: after 8 bits, if `rx_ready`=1, pulse `rx_valid` and -> RX_ACK. If `rx_ready`=0, pulse `nack_err`, leave `rx_data` unchanged, release SDA for bit 9 and -> WAIT_STOP.
  - RX_ACK: drive the ACK, then -> RX_BYTE.
  - TX_BYTE: `sda_oe` = ~bit, MSB first, each bit updated on SCL falling. After the 8th bit SDA is released -> TX_ACK.
  - TX_ACK: sample the master's bit 9 on SCL rising. ACK (0) -> TX_BYTE with a `tx_req` pulse on the next SCL falling. NACK (1) -> WAIT_STOP.
  - WAIT_STOP: SDA released; waits for STOP or a repeated START.
- Repeated START in any state -> ADDR with the bit counter cleared and `sda_oe`=0.
- STOP in any state -> IDLE with `sda_oe`=0.
- Reset mid-transfer: all state is cleared immediately, SDA is released, and the controller waits in IDLE for the next START.

## Timing
- Reset values: `sda_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `rw`=0, `busy`=0, `nack_err`=0, FSM=IDLE.
- Pin-to-action latency: `SYNC_STAGES`+1 `pclk` cycles from a pin edge to the FSM reaction.
- `sda_oe` changes `SYNC_STAGES`+2 cycles after the SCL falling edge. The SCL low time must exceed this.
- `rx_valid` asserts `SYNC_STAGES`+2 cycles after the rising SCL of data bit 8.
- `busy` rises one cycle after START is detected and falls one cycle after STOP is detected.
- Output pulses (`rx_valid`, `tx_req`, `nack_err`) are exactly one `pclk` wide.

## Configuration
- `I2C_SLAVE_GENERAL_CALL_EN`
  - Defined: address 7'h00 with R/W=0 is also ACKed and handled as a write. With R/W=1 it is not ACKed.
  - Undefined: only `SLAVE_ADDR` is matched; 7'h00 -> WAIT_STOP.

## Test plan
- Write 0xD0 (addr 7'h68, W), then 0x5A and STOP, with `rx_ready`=1 -> ACK on both bit-9 slots; `rx_valid` pulses once with `rx_data`=8'h5A; `busy` returns to 0.
- Read 0xD1, `tx_data`=8'hA5, master NACKs -> one `tx_req` pulse; SDA carries 1010_0101; FSM ends in WAIT_STOP, then IDLE after STOP.
- Address 0xA0 -> no ACK (`sda_oe`=0 throughout); no `rx_valid`/`tx_req`.
- Write 0xD0, 0x11 with `rx_ready`=0 -> `nack_err` pulses; bit 9 is released; `rx_data` unchanged.
- Repeated START after the address ACK, then 0xD1 -> `rw`=1 and `tx_req` pulses.
- Address 0x00 (write) -> ACKed with the macro defined, NACKed without it.
